led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the single-pattern LED rotator: drives a WIDTH-bit LED bank from a programmable step divider.
- Four selectable modes: rotate left, rotate right, bounce, binary count.
- Adds enable/pause, runtime speed select, synchronous pattern load and a step strobe for board-level demo logic.
- Sits between the board top level and the LED pins.

Parameters:
- WIDTH, 16, number of LED outputs (>= 2).
- DIV, 5000000, base clock cycles per step at speed=0 (>= 1).
- CNT_W, 32, divider counter width; must hold DIV-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en  input  1  1 = run; 0 = pause (counter and pattern hold)
- mode  input  2  00 rotate left, 01 rotate right, 10 bounce, 11 binary count up
- speed  input  2  step period P = max(DIV >> speed, 1) cycles
- load  input  1  synchronous pattern load strobe
- load_val  input  WIDTH  pattern written on load
- led  output  WIDTH  registered LED pattern
- step  output  1  registered; high for exactly the cycle in which led shows a newly stepped value

Behaviour:
- Reset (rst=1 at posedge), dominating all other inputs:
  - led = 1 (LSB only), cnt = 0, dir = 0 (left), step = 0.
- Divider:
  - P is recomputed combinationally from speed every cycle.
  - When en=1 and load=0: if cnt >= P-1, then cnt <= 0 and a step event fires; otherwise cnt <= cnt+1.
  - When en=0: cnt, led and dir hold; step = 0.
  - Speed change mid-period: the ">=" compare guarantees a step within one cycle if cnt already exceeds the new P-1. The counter never runs away.
  - With the reset value cnt=0, the first step fires P cycles after reset release.
- Load (load=1, rst=0), priority over a step event in the same cycle, regardless of en:
  - led <= load_val, cnt <= 0, dir <= 0, step <= 0.
- Step event: led updates on the same edge and step <= 1; otherwise step <= 0.
  - mode 00: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
  - mode 01: led <= {led[0], led[WIDTH-1:1]}.
  - mode 10 (bounce): logical shift without wrap.
    - dir=0: if led[WIDTH-1]=1, then dir <= 1 and led <= led >> 1; else led <= led << 1.
    - dir=1: if led[0]=1, then dir <= 0 and led <= led << 1; else led <= led >> 1.
    - If led == 0 at the step, led <= 1 and dir <= 0 (recovers from an all-zero load).
  - mode 11: led <= led + 1, modulo 2^WIDTH (all-ones wraps to 0).
- Mode change: takes effect at the next step event; cnt is not disturbed.
  - dir is forced to 0 on any step while mode != 10, so entering bounce always starts moving left.
- Rotate modes preserve popcount. An all-zero pattern stays zero in modes 00/01 (by design; only bounce self-recovers).
- Latency:
  - led changes only on step, load or reset edges.
  - step pulse width is 1 cycle.
  - Step spacing is exactly P cycles in steady state with en held high.

Test Plan:
- Reset/rotate left (WIDTH=8, DIV=4, speed=0, mode=00, en=1): release rst -> led 0x01; step at cycles 4, 8, 12 gives 0x02, 0x04, 0x08; after 8 steps, 0x01 again; step high exactly 1 cycle every 4.
- Rotate right and speed (mode=01, DIV=8):
  - speed=0 -> steps every 8 cycles, 0x01 -> 0x80 -> 0x40.
  - Switch speed=2 with cnt=5 -> step on the next cycle, then every 2 cycles.
- Bounce (mode=10, load_val=0x40):
  - Steps give 0x80, 0x40 (reversal at MSB), ... 0x01, 0x02 (reversal at LSB).
  - load_val=0x00 -> first step gives 0x01.
- Binary count/wrap (mode=11, load 0xFE) -> steps give 0xFF, 0x00, 0x01.
- Pause and load priority:
  - en=0 for 10 cycles -> led and cnt frozen, step=0; resume -> next step after the remaining cycles.
  - load=1 in the same cycle as a step event -> led=load_val, step=0, cnt=0.
- Reset mid-operation:
  - rst asserted with led=0x5A, dir=1, cnt=2 -> next cycle led=0x01, step=0.
  - rst=1 together with load=1 -> reset wins.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED bank pattern generator: programmable step divider driving rotate-left,
// rotate-right, bounce or binary-count patterns, with pause, speed select and load.
module led_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int DIV   = 5000000,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [1:0]       speed,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic             dir;
    logic             fire;
    logic [WIDTH-1:0] led_nxt;
    logic             dir_nxt;

    // Step period; clamp to one cycle when the shift would underflow to zero.
    always_comb begin
        per = DIV_C >> speed;
        if (per == '0)
            per = ONE_C;
    end

    // ">=" rather than "==" so a speed-up mid-period steps immediately.
    assign fire = en && (cnt >= per - ONE_C);

    always_comb begin
        led_nxt = led;
        dir_nxt = 1'b0;
        case (mode)
            2'b00: led_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
            2'b01: led_nxt = {led[0], led[WIDTH-1:1]};
            2'b10: begin
                dir_nxt = dir;
                if (led == '0) begin
                    led_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
                    dir_nxt = 1'b0;
                end else if (!dir) begin
                    if (led[WIDTH-1]) begin
                        dir_nxt = 1'b1;
                        led_nxt = led >> 1;
                    end else begin
                        led_nxt = led << 1;
                    end
                end else begin
                    if (led[0]) begin
                        dir_nxt = 1'b0;
                        led_nxt = led << 1;
                    end else begin
                        led_nxt = led >> 1;
                    end
                end
            end
            default: led_nxt = led + 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led  <= {{(WIDTH-1){1'b0}}, 1'b1};
            cnt  <= '0;
            dir  <= 1'b0;
            step <= 1'b0;
        end else if (load) begin
            led  <= load_val;
            cnt  <= '0;
            dir  <= 1'b0;
            step <= 1'b0;
        end else if (fire) begin
            led  <= led_nxt;
            cnt  <= '0;
            dir  <= dir_nxt;
            step <= 1'b1;
        end else begin
            if (en)
                cnt <= cnt + ONE_C;
            step <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen at WIDTH=8, DIV=8 (speed=1 gives a 4-cycle period).
module tb_led_pattern_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] led;
    logic       step;

    int nvec = 0;
    int nerr = 0;

    led_pattern_gen #(.WIDTH(8), .DIV(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .speed(speed),
        .load(load), .load_val(load_val), .led(led), .step(step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sample outputs away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 2'b00; speed = 2'd1; load = 1'b0; load_val = 8'h00;
        tick(); tick();
        nvec++; if (led !== 8'h01) begin nerr++; $display("FAIL reset_led: got %h want 01", led); end
        nvec++; if (step !== 1'b0) begin nerr++; $display("FAIL reset_step: got %b want 0", step); end
        rst = 1'b0;
    endtask

    task automatic test_rotate_left();
        logic [7:0] tab [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [7:0] exp_led = 8'h01;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i % 4 == 0) exp_led = tab[(i/4 - 1) % 8];
            nvec++; if (step !== (i % 4 == 0)) begin nerr++; $display("FAIL rol_step cyc %0d: got %b want %b", i, step, (i % 4 == 0)); end
            nvec++; if (led !== exp_led) begin nerr++; $display("FAIL rol_led cyc %0d: got %h want %h", i, led, exp_led); end
        end
    endtask

    task automatic test_rotate_right_speed();
        logic [7:0] exp_led = 8'h01;
        mode = 2'b01; speed = 2'd0; load = 1'b1; load_val = 8'h01;
        tick();
        load = 1'b0;
        nvec++; if (led !== 8'h01 || step !== 1'b0) begin nerr++; $display("FAIL ror_load: got %h/%b want 01/0", led, step); end
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 8)  exp_led = 8'h80;
            if (i == 16) exp_led = 8'h40;
            nvec++; if (step !== (i == 8 || i == 16)) begin nerr++; $display("FAIL ror_step cyc %0d: got %b", i, step); end
            nvec++; if (led !== exp_led) begin nerr++; $display("FAIL ror_led cyc %0d: got %h want %h", i, led, exp_led); end
        end
        // cnt is now 5; a period of 2 must step on the very next edge
        speed = 2'd2;
        tick();
        nvec++; if (step !== 1'b1 || led !== 8'h20) begin nerr++; $display("FAIL speedup_first: got %h/%b want 20/1", led, step); end
        tick();
        nvec++; if (step !== 1'b0 || led !== 8'h20) begin nerr++; $display("FAIL speedup_gap1: got %h/%b want 20/0", led, step); end
        tick();
        nvec++; if (step !== 1'b1 || led !== 8'h10) begin nerr++; $display("FAIL speedup_step2: got %h/%b want 10/1", led, step); end
        tick();
        nvec++; if (step !== 1'b0 || led !== 8'h10) begin nerr++; $display("FAIL speedup_gap2: got %h/%b want 10/0", led, step); end
        tick();
        nvec++; if (step !== 1'b1 || led !== 8'h08) begin nerr++; $display("FAIL speedup_step3: got %h/%b want 08/1", led, step); end
    endtask

    task automatic test_fastest();
        logic [7:0] tab [4] = '{8'h04, 8'h02, 8'h01, 8'h80};
        speed = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++; if (step !== 1'b1 || led !== tab[i]) begin nerr++; $display("FAIL p1_step %0d: got %h/%b want %h/1", i, led, step, tab[i]); end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] tab [10] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        logic [7:0] exp_led = 8'h40;
        mode = 2'b10; speed = 2'd1; load = 1'b1; load_val = 8'h40;
        tick();
        load = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c == 4) exp_led = tab[k];
                nvec++; if (step !== (c == 4) || led !== exp_led) begin nerr++; $display("FAIL bounce %0d.%0d: got %h/%b want %h/%b", k, c, led, step, exp_led, (c == 4)); end
            end
        end
        load = 1'b1; load_val = 8'h00;
        tick();
        load = 1'b0;
        tick(); tick(); tick(); tick();
        nvec++; if (step !== 1'b1 || led !== 8'h01) begin nerr++; $display("FAIL bounce_zero: got %h/%b want 01/1", led, step); end
    endtask

    task automatic test_count();
        logic [7:0] tab [3] = '{8'hFF, 8'h00, 8'h01};
        mode = 2'b11; speed = 2'd1; load = 1'b1; load_val = 8'hFE;
        tick();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); tick(); tick(); tick();
            nvec++; if (step !== 1'b1 || led !== tab[k]) begin nerr++; $display("FAIL count %0d: got %h/%b want %h/1", k, led, step, tab[k]); end
        end
    endtask

    task automatic test_pause_load();
        mode = 2'b00; speed = 2'd1; load = 1'b1; load_val = 8'h01;
        tick();
        load = 1'b0;
        tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++; if (step !== 1'b0 || led !== 8'h01) begin nerr++; $display("FAIL pause %0d: got %h/%b want 01/0", i, led, step); end
        end
        en = 1'b1;
        tick();
        nvec++; if (step !== 1'b0 || led !== 8'h01) begin nerr++; $display("FAIL resume_wait: got %h/%b want 01/0", led, step); end
        tick();
        nvec++; if (step !== 1'b1 || led !== 8'h02) begin nerr++; $display("FAIL resume_step: got %h/%b want 02/1", led, step); end
        tick(); tick(); tick();
        // next edge would step; load must win
        load = 1'b1; load_val = 8'hA5;
        tick();
        load = 1'b0;
        nvec++; if (step !== 1'b0 || led !== 8'hA5) begin nerr++; $display("FAIL load_prio: got %h/%b want a5/0", led, step); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            nvec++; if (step !== (c == 4) || led !== ((c == 4) ? 8'h4B : 8'hA5)) begin nerr++; $display("FAIL load_cnt %0d: got %h/%b", c, led, step); end
        end
        en = 1'b0; load = 1'b1; load_val = 8'h3C;
        tick();
        load = 1'b0;
        nvec++; if (step !== 1'b0 || led !== 8'h3C) begin nerr++; $display("FAIL load_paused: got %h/%b want 3c/0", led, step); end
        en = 1'b1;
    endtask

    task automatic test_reset_mid();
        mode = 2'b10; speed = 2'd1; load = 1'b1; load_val = 8'hB4;
        tick();
        load = 1'b0;
        tick(); tick(); tick(); tick();
        nvec++; if (step !== 1'b1 || led !== 8'h5A) begin nerr++; $display("FAIL pre_reset: got %h/%b want 5a/1", led, step); end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++; if (step !== 1'b0 || led !== 8'h01) begin nerr++; $display("FAIL reset_mid: got %h/%b want 01/0", led, step); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            nvec++; if (step !== (c == 4) || led !== ((c == 4) ? 8'h02 : 8'h01)) begin nerr++; $display("FAIL post_reset %0d: got %h/%b", c, led, step); end
        end
        rst = 1'b1; load = 1'b1; load_val = 8'hFF;
        tick();
        rst = 1'b0; load = 1'b0;
        nvec++; if (step !== 1'b0 || led !== 8'h01) begin nerr++; $display("FAIL reset_vs_load: got %h/%b want 01/0", led, step); end
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right_speed();
        test_fastest();
        test_bounce();
        test_count();
        test_pause_load();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
